// File: rtl/cpu_loader_pkg.sv
// Shared types and defaults for the CPU front-panel loader.
package cpu_loader_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_GAP_CYC   = 4;

    typedef enum logic [3:0] {
        IDLE, GET_A, DRV_A, GAP_A, GET_D, DRV_D, GAP_D,
        CHK, EXEC, GAP_X, RUN, FEED, GAP_F
    } state_t;

    function automatic logic is_pulse(input state_t s);
        return (s == DRV_A) || (s == DRV_D) || (s == EXEC) || (s == FEED);
    endfunction

    function automatic logic is_gap(input state_t s);
        return (s == GAP_A) || (s == GAP_D) || (s == GAP_X) || (s == GAP_F);
    endfunction

endpackage

// File: rtl/cpu_loader_strobe_timer.sv
// Phase timer shared by every strobe pulse and gap: reload on phase entry, count down, done at zero.
module strobe_timer
    import cpu_loader_pkg::*;
#(
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sel_gap,
    output logic done
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    logic [TW-1:0] cnt;

    // Loading length-1 makes a phase last exactly its length, counting the entry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= sel_gap ? TW'(GAP_CYC - 1) : TW'(PULSE_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cpu_loader.sv
// Front-panel loader: streams (addr,data) pairs into CPU memory, starts it, and feeds its input requests.
// Optional checksum byte after the last pair is enabled by defining CPU_LOADER_CHECKSUM_EN.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int CNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [BYTE_W-1:0] o_data_out,
    output logic              o_load_addr,
    output logic              o_load_data,
    output logic              o_execute,
    output logic              o_input_taken,
    input  logic              i_cpu_waiting,
    input  logic              i_cpu_take_input,
    output logic              o_busy,
    output logic              o_running,
    output logic              o_error
);

`ifdef CPU_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CHK;
`else
    localparam state_t LOAD_END = EXEC;
`endif

    state_t           state, next_state;
    logic             accept;
    logic             tmr_load, tmr_gap, tmr_done;
    logic [CNT_W-1:0] remaining;

`ifdef CPU_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic              chk_ok;
    assign chk_ok = (i_rx_data == csum);
`endif

    strobe_timer #(
        .PULSE_CYC(PULSE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) u_timer (
        .clk    (i_clk),
        .reset  (i_reset),
        .load   (tmr_load),
        .sel_gap(tmr_gap),
        .done   (tmr_done)
    );

    always_comb begin
        o_rx_ready = 1'b0;
        case (state)
            IDLE, GET_A, GET_D, CHK: o_rx_ready = 1'b1;
            RUN:                     o_rx_ready = i_cpu_take_input;
            default:                 o_rx_ready = 1'b0;
        endcase
        if (i_reset) o_rx_ready = 1'b0;
        accept = o_rx_ready && i_rx_valid;

        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = (i_rx_data != '0) ? GET_A : LOAD_END;
            GET_A: if (accept) next_state = DRV_A;
            DRV_A: if (tmr_done) next_state = GAP_A;
            GAP_A: if (tmr_done) next_state = GET_D;
            GET_D: if (accept) next_state = DRV_D;
            DRV_D: if (tmr_done) next_state = GAP_D;
            GAP_D: if (tmr_done) next_state = (remaining == CNT_W'(1)) ? LOAD_END : GET_A;
`ifdef CPU_LOADER_CHECKSUM_EN
            CHK:   if (accept) next_state = chk_ok ? EXEC : IDLE;
`endif
            EXEC:  if (tmr_done) next_state = GAP_X;
            GAP_X: if (tmr_done) next_state = RUN;
            // A pending input request keeps the CPU in RUN even if it also reports waiting.
            RUN: begin
                if (i_cpu_take_input) begin
                    if (accept) next_state = FEED;
                end else if (i_cpu_waiting) begin
                    next_state = IDLE;
                end
            end
            FEED:  if (tmr_done) next_state = GAP_F;
            GAP_F: if (tmr_done) next_state = RUN;
            default: next_state = IDLE;
        endcase

        tmr_load = (next_state != state) && (is_pulse(next_state) || is_gap(next_state));
        tmr_gap  = is_gap(next_state);
    end

    // Strobes follow the state one cycle late so o_data_out is settled a full cycle before each rise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            o_data_out    <= '0;
            remaining     <= '0;
            o_load_addr   <= 1'b0;
            o_load_data   <= 1'b0;
            o_execute     <= 1'b0;
            o_input_taken <= 1'b0;
        end else begin
            state         <= next_state;
            o_load_addr   <= (state == DRV_A);
            o_load_data   <= (state == DRV_D);
            o_execute     <= (state == EXEC);
            o_input_taken <= (state == FEED);
            if (accept && (state == GET_A || state == GET_D || state == RUN))
                o_data_out <= i_rx_data;
            if (accept && state == IDLE)
                remaining <= CNT_W'(i_rx_data);
            else if (state == GAP_D && tmr_done)
                remaining <= remaining - CNT_W'(1);
        end
    end

`ifdef CPU_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csum    <= '0;
            o_error <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) csum <= i_rx_data;
            else if (state == GET_A || state == GET_D) csum <= csum + i_rx_data;
            if (state == CHK && !chk_ok) o_error <= 1'b1;
        end
    end
`else
    assign o_error = 1'b0;
`endif

    assign o_busy    = (state != IDLE);
    assign o_running = (state == RUN) || (state == FEED);

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: table of load streams plus hand-written RUN/FEED, reset-abort and checksum sequences.
module tb_cpu_loader;

    localparam int PULSE = 4;
    localparam int GAP   = 4;
    localparam logic [1:0] KA = 2'd0, KD = 2'd1, KX = 2'd2, KT = 2'd3;
`ifdef CPU_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       i_clk, i_reset, i_rx_valid, o_rx_ready;
    logic [7:0] i_rx_data, o_data_out;
    logic       o_load_addr, o_load_data, o_execute, o_input_taken;
    logic       i_cpu_waiting, i_cpu_take_input, o_busy, o_running, o_error;

    cpu_loader #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_rx_ready(o_rx_ready), .o_data_out(o_data_out), .o_load_addr(o_load_addr),
        .o_load_data(o_load_data), .o_execute(o_execute), .o_input_taken(o_input_taken),
        .i_cpu_waiting(i_cpu_waiting), .i_cpu_take_input(i_cpu_take_input),
        .o_busy(o_busy), .o_running(o_running), .o_error(o_error)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int ovl_err = 0, rdy_err = 0, stab_err = 0, gap_err = 0, busy_err = 0;
    int last_acc = 0;

    typedef struct { int kind; logic [7:0] data; int len; int rise; } ev_t;
    ev_t ev_q[$];

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        int          ne;
        logic [15:0] kinds;
        logic [63:0] edata;
        int          gap;
        int          trig;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: records each pulse and watches overlap, ready, data hold and gap length.
    initial begin
        int          low_cnt;
        logic        prev_any, any;
        logic [7:0]  prev_dout;
        ev_t         cur;
        low_cnt = 1000; prev_any = 1'b0; prev_dout = 8'h00;
        cur = '{0, 8'h00, 0, 0};
        forever begin
            @(negedge i_clk);
            any = o_load_addr | o_load_data | o_execute | o_input_taken;
            if (i_reset) begin
                low_cnt = 1000;
                any = 1'b0;
            end else begin
                if ($countones({o_load_addr, o_load_data, o_execute, o_input_taken}) > 1) ovl_err++;
                if (any && o_rx_ready) rdy_err++;
                if (any && !o_busy) busy_err++;
                if (any && !prev_any) begin
                    if (low_cnt < GAP) gap_err++;
                    if (o_data_out !== prev_dout) stab_err++;
                    cur.kind = o_load_addr ? 0 : o_load_data ? 1 : o_execute ? 2 : 3;
                    cur.data = o_data_out;
                    cur.len  = 1;
                    cur.rise = cyc;
                end else if (any) begin
                    cur.len++;
                    if (o_data_out !== cur.data) stab_err++;
                end else begin
                    if (prev_any) begin
                        ev_q.push_back(cur);
                        low_cnt = 1;
                    end else if (low_cnt < 1000) begin
                        low_cnt++;
                    end
                    if (low_cnt <= GAP - 1 && o_rx_ready) rdy_err++;
                    if (low_cnt <= GAP && o_data_out !== cur.data) stab_err++;
                end
            end
            prev_any  = any;
            prev_dout = o_data_out;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        n = 0;
        while (!o_rx_ready && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted, required accept within 1000 cycles", b);
            i_rx_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check(name, o_busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin
        int acc[8];
        int n;
        i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0;

        vecs[0] = '{3 + CS, 64'h01_10_AB_BC_00_00_00_00, 3, {KA, KD, KX, 10'd0},
                    64'h10_AB_00_00_00_00_00_00, 0, 1};
        vecs[1] = '{1 + CS, 64'h00_00_00_00_00_00_00_00, 1, {KX, 14'd0},
                    64'h00_00_00_00_00_00_00_00, 0, CS};
        vecs[2] = '{7 + CS, 64'h03_01_11_02_22_03_33_6F, 7, {KA, KD, KA, KD, KA, KD, KX, 2'd0},
                    64'h01_11_02_22_03_33_00_00, 3, 1};
        vecs[3] = '{5 + CS, 64'h02_FF_00_80_7F_00_00_00, 5, {KA, KD, KA, KD, KX, 6'd0},
                    64'hFF_00_80_7F_00_00_00_00, 1, 1};

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_strobes", {o_load_addr, o_load_data, o_execute, o_input_taken}, 4'b0000);
        check("rst_ready", o_rx_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_running", o_running, 1'b0);
        check("rst_data", o_data_out, 8'h00);
        check("rst_error", o_error, 1'b0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("idle_ready", o_rx_ready, 1'b1);

        // Table of load streams, CPU reports waiting so each run ends back in IDLE
        for (int v = 0; v < 4; v++) begin
            ev_q.delete();
            for (int i = 0; i < vecs[v].nb; i++) begin
                send_byte(vecs[v].bytes[63 - 8*i -: 8], vecs[v].gap);
                acc[i] = last_acc;
            end
            wait_idle($sformatf("v%0d_idle", v));
            check($sformatf("v%0d_nevents", v), ev_q.size(), vecs[v].ne);
            for (int e = 0; e < vecs[v].ne && e < ev_q.size(); e++) begin
                check($sformatf("v%0d_kind%0d", v, e), ev_q[e].kind, 32'(vecs[v].kinds[15 - 2*e -: 2]));
                check($sformatf("v%0d_len%0d", v, e), ev_q[e].len, PULSE);
                if (vecs[v].kinds[15 - 2*e -: 2] != KX)
                    check($sformatf("v%0d_data%0d", v, e), ev_q[e].data, vecs[v].edata[63 - 8*e -: 8]);
            end
            if (ev_q.size() > 0)
                check($sformatf("v%0d_latency", v), ev_q[0].rise - acc[vecs[v].trig], 2);
        end
        check("no_error_after_loads", o_error, 1'b0);

        // RUN: take_input beats waiting, then one input byte is fed
        i_cpu_waiting = 1'b0;
        send_byte(8'h00, 0);
        if (CS != 0) send_byte(8'h00, 0);
        n = 0;
        while (!o_running && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("run_entered", o_running, 1'b1);
        check("run_ready_no_req", o_rx_ready, 1'b0);
        i_cpu_take_input = 1'b1;
        i_cpu_waiting    = 1'b1;
        repeat (3) @(negedge i_clk);
        check("take_wins_running", o_running, 1'b1);
        check("take_wins_ready", o_rx_ready, 1'b1);
        ev_q.delete();
        send_byte(8'h5A, 0);
        i_cpu_take_input = 1'b0;
        i_cpu_waiting    = 1'b0;
        n = 0;
        while (ev_q.size() == 0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        repeat (GAP + 2) @(negedge i_clk);
        check("feed_nevents", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check("feed_kind", ev_q[0].kind, 32'(KT));
            check("feed_len", ev_q[0].len, PULSE);
            check("feed_data", ev_q[0].data, 8'h5A);
            check("feed_latency", ev_q[0].rise - last_acc, 2);
        end
        check("feed_back_running", o_running, 1'b1);
        check("feed_data_held", o_data_out, 8'h5A);
        i_cpu_waiting = 1'b1;
        @(negedge i_clk);
        check("run_exit_busy", o_busy, 1'b0);
        check("run_exit_running", o_running, 1'b0);

        // Reset in the 2nd cycle of o_load_data aborts everything on that edge
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'hAB, 0);
        n = 0;
        while (!o_load_data && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        check("abort_ld_high", o_load_data, 1'b1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("abort_strobes", {o_load_addr, o_load_data, o_execute, o_input_taken}, 4'b0000);
        check("abort_busy", o_busy, 1'b0);
        check("abort_data", o_data_out, 8'h00);
        check("abort_ready", o_rx_ready, 1'b0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("abort_idle_ready", o_rx_ready, 1'b1);
        ev_q.delete();

`ifdef CPU_LOADER_CHECKSUM_EN
        // Bad checksum: no execute, sticky error until reset
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hBD, 0);
        wait_idle("bad_cs_idle");
        check("bad_cs_error", o_error, 1'b1);
        check("bad_cs_nevents", ev_q.size(), 2);
        n = 0;
        foreach (ev_q[k]) if (ev_q[k].kind == 2) n++;
        check("bad_cs_no_exec", n, 0);
        ev_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_idle("sticky_idle");
        check("sticky_error", o_error, 1'b1);
        check("sticky_exec", ev_q.size(), 1);
        do_reset();
        check("error_cleared", o_error, 1'b0);
`endif

        // Pulse-level invariants collected across the whole run
        check("no_overlap", ovl_err, 0);
        check("ready_low_in_drv_gap", rdy_err, 0);
        check("data_stable", stab_err, 0);
        check("gap_length", gap_err, 0);
        check("busy_during_strobe", busy_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
